seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run-time configurable serial pattern-detection controller for the sequence-detector datapath. It holds the pattern configuration (bits, length, overlap mode) and sequences arm/disarm of detection on a qualified serial bit stream. It emits a one-cycle match pulse and keeps a saturating match counter for status readout. It sits between the serial input front end and the status/interrupt logic, replacing fixed-pattern detectors with a single programmable instance.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..16).
- CNTW, 16: width of match counter.

- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe, accepted only in IDLE.
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first-received bit, bit [0] the most recent.
- cfg_len  input  $clog2(MAXLEN+1)  pattern length, legal 1..MAXLEN.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
- start  input  1  arm detection (IDLE→RUN).
- stop  input  1  disarm detection (RUN→IDLE).
- in_valid  input  1  qualifies in for this cycle.
- in  input  1  serial data bit.
- out  output  1  registered one-cycle match pulse.
- match_count  output  CNTW  saturating count of matches since last start.
- busy  output  1  high in RUN.
- cfg_err  output  1  one-cycle pulse on rejected config write.

## Operation
- States: IDLE, RUN. busy = (state == RUN).
- Registers: cfg pattern/len/overlap, history shift register hist[MAXLEN-1:0], fill counter (0..MAXLEN), match_count.
- Reset values: state IDLE, pattern = 0…01101, len = 4, overlap = 1, hist = 0, fill = 0, match_count = 0, out = 0, cfg_err = 0.
- IDLE:
  - cfg_we with 1 ≤ cfg_len ≤ MAXLEN loads all three config fields.
  - Otherwise cfg_err pulses and the old config is kept.
  - start clears hist, fill and match_count, then enters RUN.
  - start and stop together: stop wins, stay IDLE.
  - in_valid is ignored.
- RUN:
  - cfg_we is ignored and pulses cfg_err.
  - start is ignored.
  - stop enters IDLE; an in_valid in the same cycle is dropped, with no match and no history update. hist, fill and match_count are retained for readout.
- RUN with in_valid and no stop:
  - Shift: hist_n = {hist[MAXLEN-2:0], in}; fill_n = min(fill+1, MAXLEN).
  - Match when fill_n ≥ len and hist_n[len-1:0] == pattern[len-1:0].
  - On match: out = 1 next cycle; match_count increments unless all-ones (saturate).
  - On match with overlap = 0: fill ← 0, so the next match needs len fresh bits.
  - On match with overlap = 1: fill is kept.
- Cycles with in_valid low leave hist and fill unchanged. Gaps do not break a partial match.
- Pattern bits above len-1 are don't-care.

## Timing
- out latency: asserted exactly 1 cycle after the clk edge sampling the completing bit, for 1 cycle. Back-to-back matches on consecutive valid cycles give back-to-back pulses.
- match_count updates on the same edge that raises out.
- busy rises the cycle after start and falls the cycle after stop.
- cfg_err is asserted the cycle after the offending cfg_we.
- A config write takes effect for the next start.
- rst mid-RUN: next cycle all registers hold reset values, including the default config, and out = 0.
- No combinational path from inputs to outputs.

## Test plan
- Defaults, overlap: reset, start, valid bits 1,1,0,1,1,0,1 on consecutive cycles → out pulses after bits 4 and 7, match_count = 2.
- Non-overlap: config 4'b1010, len 4, overlap 0; start; bits 1,0,1,0,1,0 → single pulse after bit 4, match_count = 1. Same run with overlap 1 → pulses after bits 4 and 6, count = 2.
- Config errors: cfg_len = 0 in IDLE → cfg_err pulse, config unchanged (default 1101 still matches). cfg_we in RUN → cfg_err, detection unaffected.
- Valid gaps: 1101 sent with 3 idle cycles between every bit → one pulse, 1 cycle after the last valid bit. in toggling while in_valid is low → no effect.
- Saturation: CNTW = 2, pattern len 1 = 1'b1, 5 valid ones → pulses every cycle, match_count stops at 3.
- Stop and reset: stop asserted with the completing bit of 1101 → no pulse, busy falls, count held. Restart → count cleared. rst mid-stream → out 0, config returns to 1101/len 4.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time configurable serial pattern-detection controller.
// Holds the pattern configuration, arms/disarms detection on a qualified serial
// bit stream, emits a registered one-cycle match pulse and keeps a saturating
// match counter.
//
// Ports:
//   clk          single clock, all state on rising edge
//   rst          synchronous active-high reset
//   cfg_we       config write strobe (accepted only when idle)
//   cfg_pattern  pattern, bit [len-1] first received, bit [0] most recent
//   cfg_len      pattern length, legal 1..MAXLEN
//   cfg_overlap  1 = overlapping matches, 0 = history restarts after a match
//   start        arm detection
//   stop         disarm detection (wins over start)
//   in_valid     qualifies in
//   in           serial data bit
//   out          registered one-cycle match pulse
//   match_count  saturating match count since last start
//   busy         high while armed
//   cfg_err      one-cycle pulse on a rejected config write
module seq_detect_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 16,
  localparam int unsigned LW    = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in,
  output logic              out,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              cfg_err
);

  localparam logic [MAXLEN-1:0] DefPattern = MAXLEN'(4'b1101);
  localparam logic [LW-1:0]     DefLen     = LW'(4);
  localparam logic [LW-1:0]     MaxLen     = LW'(MAXLEN);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [MAXLEN-1:0]   pattern_q, pattern_d;
  logic [LW-1:0]       len_q, len_d;
  logic                overlap_q, overlap_d;
  logic [MAXLEN-1:0]   hist_q, hist_d;
  logic [LW-1:0]       fill_q, fill_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                err_q, err_d;

  logic [MAXLEN-1:0]   hist_shift;
  logic [LW-1:0]       fill_inc;
  logic [MAXLEN-1:0]   len_mask;
  logic                hit;

  // Candidate history/fill if the current bit is accepted.
  always_comb begin
    hist_shift = {hist_q[MAXLEN-2:0], in};
    fill_inc   = (fill_q == MaxLen) ? fill_q : fill_q + LW'(1);
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    // Pattern bits at or above len are masked off as don't-care.
    hit = (fill_inc >= len_q) && (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    out_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          if ((cfg_len != '0) && (cfg_len <= MaxLen)) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start && !stop) begin
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cfg_we) begin
          err_d = 1'b1;
        end
        if (stop) begin
          // Any bit arriving with stop is dropped; history stays for readout.
          state_d = StIdle;
        end else if (in_valid) begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (hit) begin
            out_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNTW'(1);
            end
            if (!overlap_q) begin
              fill_d = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pattern_q <= DefPattern;
      len_q     <= DefLen;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign busy        = (state_q == StRun);
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: directed scenarios followed by random
// stimulus, checked every cycle against a bit-list reference model. Two
// instances share the stimulus; the second uses a 2-bit counter to exercise
// saturation.
module tb_seq_detect_ctrl;

  localparam int unsigned MAXLEN = 8;
  localparam int unsigned LW     = 4;

  logic              clk = 1'b0;
  logic              rst, cfg_we, cfg_overlap, start, stop, in_valid, in_bit;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic              out0, out1, busy0, busy1, err0, err1;
  logic [15:0]       cnt0;
  logic [1:0]        cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run;
  bit          m_bits[$];
  int          m_fresh;
  int          m_cnt;
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  bit          m_out;
  bit          m_err;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(16)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .in_valid(in_valid), .in(in_bit), .out(out0), .match_count(cnt0),
    .busy(busy0), .cfg_err(err0)
  );

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(2)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .in_valid(in_valid), .in(in_bit), .out(out1), .match_count(cnt1),
    .busy(busy1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit tail_matches();
    int sz = m_bits.size();
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[sz-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Apply the rules to the inputs about to be sampled.
  task automatic model_step();
    if (rst) begin
      m_run = 0; m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1;
      m_cnt = 0; m_fresh = 0; m_bits.delete(); m_out = 0; m_err = 0;
    end else begin
      m_out = 0;
      m_err = 0;
      if (!m_run) begin
        if (cfg_we) begin
          if (cfg_len >= 1 && cfg_len <= MAXLEN) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          end else begin
            m_err = 1;
          end
        end
        if (start && !stop) begin
          m_run = 1; m_cnt = 0; m_fresh = 0; m_bits.delete();
        end
      end else begin
        if (cfg_we) m_err = 1;
        if (stop) begin
          m_run = 0;
        end else if (in_valid) begin
          m_bits.push_back(in_bit);
          if (m_bits.size() > MAXLEN) void'(m_bits.pop_front());
          m_fresh++;
          if (m_fresh >= m_len && tail_matches()) begin
            m_out = 1;
            m_cnt++;
            if (!m_ovl) m_fresh = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("out0", 32'(out0), 32'(m_out));
    check("out1", 32'(out1), 32'(m_out));
    check("busy", 32'(busy0), 32'(m_run));
    check("cfg_err", 32'(err0), 32'(m_err));
    check("cnt16", 32'(cnt0), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    check("cnt2", 32'(cnt1), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
  endtask

  task automatic clr();
    rst = 0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    start = 0; stop = 0; in_valid = 0; in_bit = 0;
  endtask

  task automatic bit_in(input bit b);
    clr(); in_valid = 1; in_bit = b; step();
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    logic [15:0] v = bits;
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic do_start(); clr(); start = 1; step(); endtask
  task automatic do_stop();  clr(); stop = 1;  step(); endtask
  task automatic do_rst();   clr(); rst = 1;   step(); endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
    clr(); cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; step();
  endtask

  initial begin
    clr();
    do_rst();
    do_rst();
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);

    // Default pattern 1101, overlapping
    do_start();
    send(16'b1101101, 7);
    check("dflt_cnt", 32'(cnt0), 32'd2);

    // 1010 non-overlap then overlap
    do_stop();
    do_cfg(8'b1010, 4'd4, 1'b0);
    do_start();
    send(16'b101010, 6);
    check("ovl0_cnt", 32'(cnt0), 32'd1);
    do_stop();
    do_cfg(8'b1010, 4'd4, 1'b1);
    do_start();
    send(16'b101010, 6);
    check("ovl1_cnt", 32'(cnt0), 32'd2);

    // Config errors
    do_rst();
    do_cfg(8'hff, 4'd0, 1'b0);
    check("err_idle", 32'(err0), 32'd1);
    do_cfg(8'hff, 4'd9, 1'b0);
    check("err_long", 32'(err0), 32'd1);
    do_start();
    do_cfg(8'h0f, 4'd3, 1'b0);
    check("err_run", 32'(err0), 32'd1);
    send(16'b1101, 4);
    check("err_cnt", 32'(cnt0), 32'd1);

    // Valid gaps with toggling data
    do_stop();
    do_start();
    for (int i = 3; i >= 0; i--) begin
      bit_in(((4'b1101 >> i) & 1) != 0);
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          clr(); in_bit = g[0]; step();
        end
      end
    end
    check("gap_cnt", 32'(cnt0), 32'd1);

    // Saturation of the 2-bit counter
    do_stop();
    do_cfg(8'b1, 4'd1, 1'b1);
    do_start();
    send(16'b11111, 5);
    check("sat_cnt2", 32'(cnt1), 32'd3);
    check("sat_cnt16", 32'(cnt0), 32'd5);

    // Stop with completing bit, restart, reset mid-stream
    do_rst();
    do_start();
    send(16'b110110, 6);
    clr(); stop = 1; in_valid = 1; in_bit = 1; step();
    check("stop_out", 32'(out0), 32'd0);
    check("stop_busy", 32'(busy0), 32'd0);
    check("stop_cnt", 32'(cnt0), 32'd1);
    do_start();
    check("restart_cnt", 32'(cnt0), 32'd0);
    send(16'b110, 3);
    clr(); rst = 1; in_valid = 1; in_bit = 1; step();
    check("rst_out", 32'(out0), 32'd0);
    check("rst_busy2", 32'(busy0), 32'd0);
    do_start();
    send(16'b1101, 4);
    check("rst_cfg_cnt", 32'(cnt0), 32'd1);

    // Random stimulus
    for (int c = 0; c < 3000; c++) begin
      clr();
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 11) == 0);
      stop        = ($urandom_range(0, 24) == 0);
      cfg_we      = ($urandom_range(0, 14) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 9));
      cfg_overlap = 1'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bit      = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
